// File: rtl/uart_pkt_tx_if.sv
// Payload handshake between a packet source and uart_pkt_tx.
interface uart_pkt_tx_if;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [7:0]  data_a;
  logic [7:0]  data_d;
  logic [15:0] data_b;
  logic [15:0] data_c;

  modport master (
    output pkt_valid, data_a, data_d, data_b, data_c,
    input  pkt_ready
  );

  modport slave (
    input  pkt_valid, data_a, data_d, data_b, data_c,
    output pkt_ready
  );
endinterface

// File: rtl/uart_pkt_tx.sv
// Serialises one 6-byte payload as an 8-byte 8N1 UART packet: AA, payload, 55.
module uart_pkt_tx #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned UART_BPS = 115200
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  uart_pkt_tx_if.slave pkt_if,
  output logic         uart_txd,
  output logic         tx_busy,
  output logic         pkt_done
);

  localparam int unsigned BAUD_CNT = CLK_FREQ / UART_BPS;
  localparam int unsigned CNT_W    = (BAUD_CNT > 2) ? $clog2(BAUD_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_CNT - 1);
  localparam logic [7:0] HDR_BYTE  = 8'hAA;
  localparam logic [7:0] TAIL_BYTE = 8'h55;

  if (BAUD_CNT < 2) begin : g_baud_check
    $error("uart_pkt_tx: BAUD_CNT must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t           state_q;
  logic [63:0]      shreg_q;   // byte 0 in bits [7:0], shifted out LSB first
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       byte_q;
  logic [2:0]       bit_q;
  logic             txd_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  logic accept_c;
  logic bit_end_c;

  assign accept_c  = pkt_if.pkt_valid && ready_q;
  assign bit_end_c = (cnt_q == CNT_MAX);

  assign uart_txd         = txd_q;
  assign tx_busy          = busy_q;
  assign pkt_done         = done_q;
  assign pkt_if.pkt_ready = ready_q;

  // Packet FSM: latch on acceptance, then walk start/data/stop for all 8 bytes.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            shreg_q <= {TAIL_BYTE, pkt_if.data_c[15:8], pkt_if.data_c[7:0],
                        pkt_if.data_b[15:8], pkt_if.data_b[7:0],
                        pkt_if.data_d, pkt_if.data_a, HDR_BYTE};
            state_q <= ST_START;
            cnt_q   <= '0;
            byte_q  <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        ST_START: begin
          if (bit_end_c) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= ST_DATA;
            txd_q   <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (bit_end_c) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= ST_STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              txd_q   <= shreg_q[0];
              shreg_q <= shreg_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (bit_end_c) begin
            cnt_q <= '0;
            if (byte_q == 3'd7) begin
              state_q <= ST_IDLE;
              byte_q  <= '0;
              txd_q   <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              // Next start bit follows the stop bit directly, no idle gap.
              byte_q  <= byte_q + 3'd1;
              state_q <= ST_START;
              txd_q   <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
          txd_q   <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pkt_tx.sv
// Directed plus randomised bench for uart_pkt_tx at B = 10 cycles per bit.
module tb_uart_pkt_tx;

  localparam int unsigned B   = 10;
  localparam int unsigned PKT = 80 * B;
  localparam int MODE_NORMAL   = 0;
  localparam int MODE_SCRAMBLE = 1;
  localparam int MODE_B2B      = 2;
  localparam int MODE_IGNORE   = 3;
  localparam int MODE_ABORT    = 4;

  logic clk = 1'b0;
  logic rst;
  logic txd, busy, done;

  uart_pkt_tx_if pkt_if ();

  uart_pkt_tx #(.CLK_FREQ(1000), .UART_BPS(100)) dut (
    .sys_clk  (clk),
    .sys_rst  (rst),
    .pkt_if   (pkt_if.slave),
    .uart_txd (txd),
    .tx_busy  (busy),
    .pkt_done (done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int done_cnt = 0;
  int rise_cyc = 0;
  int fall_cyc = 0;
  logic txd_prev = 1'b1;

  logic [7:0]  exp_b [8];
  logic [7:0]  nxt_a, nxt_d;
  logic [15:0] nxt_b, nxt_c;

  // Line monitor: edges of txd and pkt_done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (txd_prev === 1'b0 && txd === 1'b1) rise_cyc = cyc;
    if (txd_prev === 1'b1 && txd === 1'b0) fall_cyc = cyc;
    txd_prev = txd;
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_payload(input logic [7:0] a, input logic [7:0] d,
                               input logic [15:0] b, input logic [15:0] c);
    pkt_if.data_a = a;
    pkt_if.data_d = d;
    pkt_if.data_b = b;
    pkt_if.data_c = c;
  endtask

  // Reference packet: header, payload bytes in wire order, tail.
  function automatic void build_model(input logic [7:0] a, input logic [7:0] d,
                                      input logic [15:0] b, input logic [15:0] c);
    exp_b[0] = 8'hAA;
    exp_b[1] = a;
    exp_b[2] = d;
    exp_b[3] = b[7:0];
    exp_b[4] = b[15:8];
    exp_b[5] = c[7:0];
    exp_b[6] = c[15:8];
    exp_b[7] = 8'h55;
  endfunction

  // Line level of packet bit k (10 bits per byte: start, 8 data LSB first, stop).
  function automatic logic model_bit(input int k);
    int j;
    int p;
    j = k / 10;
    p = k % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return exp_b[j][p-1];
  endfunction

  task automatic start_pkt(input logic keep_valid);
    check("ready_before_accept", 64'(pkt_if.pkt_ready), 64'd1);
    pkt_if.pkt_valid = 1'b1;
    tick();
    if (!keep_valid) pkt_if.pkt_valid = 1'b0;
  endtask

  // Called in cycle 1 after acceptance; returns in cycle PKT+1.
  task automatic run_packet(input int mode);
    int err;
    int first_bad;
    int k;
    int p;
    logic [7:0] dec [8];
    err = 0;
    first_bad = -1;
    for (int n = 1; n <= PKT; n++) begin
      k = (n - 1) / B;
      if (txd !== model_bit(k) || busy !== 1'b1 || pkt_if.pkt_ready !== 1'b0 || done !== 1'b0) begin
        err++;
        if (first_bad < 0) first_bad = n;
      end
      p = k % 10;
      if (((n - 1) % B) == (B / 2) && p >= 1 && p <= 8) dec[k/10][p-1] = txd;

      if (mode == MODE_SCRAMBLE && n == 1) drive_payload(8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF);
      if (mode == MODE_B2B && n == 2) drive_payload(nxt_a, nxt_d, nxt_b, nxt_c);
      if (mode == MODE_IGNORE && n == 55 * B) begin
        pkt_if.pkt_valid = 1'b1;
        drive_payload(~exp_b[1], ~exp_b[2], 16'h0F0F, 16'hF0F0);
      end
      if (mode == MODE_IGNORE && n == 55 * B + 1) pkt_if.pkt_valid = 1'b0;

      if (mode == MODE_ABORT && n == 353) begin
        check("abort_stream", 64'(err), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_txd", 64'(txd), 64'd1);
        check("abort_ready", 64'(pkt_if.pkt_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        err = 0;
        for (int i = 0; i < 2 * B; i++) begin
          tick();
          if (txd !== 1'b1 || done !== 1'b0 || pkt_if.pkt_ready !== 1'b1 || busy !== 1'b0) err++;
        end
        check("abort_quiet", 64'(err), 64'd0);
        return;
      end
      tick();
    end
    check($sformatf("stream_first_bad_cycle_%0d", first_bad), 64'(err), 64'd0);
    for (int j = 0; j < 8; j++) check($sformatf("dec_byte%0d", j), 64'(dec[j]), 64'(exp_b[j]));
    check("end_done", 64'(done), 64'd1);
    check("end_ready", 64'(pkt_if.pkt_ready), 64'd1);
    check("end_busy", 64'(busy), 64'd0);
    check("end_txd", 64'(txd), 64'd1);
  endtask

  initial begin
    int err;
    int base;
    int gap;
    logic [7:0]  ra, rd;
    logic [15:0] rb, rc;

    rst = 1'b1;
    pkt_if.pkt_valid = 1'b0;
    drive_payload(8'h00, 8'h00, 16'h0000, 16'h0000);

    // Reset held 5 cycles, then released: outputs idle throughout.
    err = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (txd !== 1'b1 || pkt_if.pkt_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) err++;
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (txd !== 1'b1 || pkt_if.pkt_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) err++;
    end
    check("reset_idle_cycles", 64'(err), 64'd0);
    check("reset_txd", 64'(txd), 64'd1);
    check("reset_ready", 64'(pkt_if.pkt_ready), 64'd1);

    // Basic packet.
    drive_payload(8'h08, 8'h00, 16'h0000, 16'h0000);
    build_model(8'h08, 8'h00, 16'h0000, 16'h0000);
    start_pkt(1'b0);
    run_packet(MODE_NORMAL);
    tick();
    check("post_done_clear", 64'(done), 64'd0);

    // Word ordering, inputs scrambled after acceptance.
    drive_payload(8'h5A, 8'hC3, 16'h1234, 16'hABCD);
    build_model(8'h5A, 8'hC3, 16'h1234, 16'hABCD);
    start_pkt(1'b0);
    run_packet(MODE_SCRAMBLE);
    repeat (3) tick();

    // Back-to-back with pkt_valid held high.
    base = done_cnt;
    drive_payload(8'h01, 8'h11, 16'h2222, 16'h3333);
    build_model(8'h01, 8'h11, 16'h2222, 16'h3333);
    nxt_a = 8'h02; nxt_d = 8'h44; nxt_b = 16'h5555; nxt_c = 16'h6666;
    start_pkt(1'b1);
    run_packet(MODE_B2B);
    build_model(nxt_a, nxt_d, nxt_b, nxt_c);
    start_pkt(1'b0);
    #6;
    gap = fall_cyc - rise_cyc;
    check("b2b_start_gap", 64'(gap), 64'd11);
    run_packet(MODE_NORMAL);
    tick();
    tick();
    check("b2b_done_pulses", 64'(done_cnt - base), 64'd2);

    // Ignored request during byte 5.
    ra = 8'($urandom); rd = 8'($urandom); rb = 16'($urandom); rc = 16'($urandom);
    drive_payload(ra, rd, rb, rc);
    build_model(ra, rd, rb, rc);
    start_pkt(1'b0);
    run_packet(MODE_IGNORE);
    tick();

    // Abort during byte 3, bit 4, then a fresh packet.
    base = done_cnt;
    ra = 8'($urandom); rd = 8'($urandom); rb = 16'($urandom); rc = 16'($urandom);
    drive_payload(ra, rd, rb, rc);
    build_model(ra, rd, rb, rc);
    start_pkt(1'b0);
    run_packet(MODE_ABORT);
    check("abort_no_done", 64'(done_cnt - base), 64'd0);
    drive_payload(8'h77, 8'h00, 16'h0000, 16'h0000);
    build_model(8'h77, 8'h00, 16'h0000, 16'h0000);
    start_pkt(1'b0);
    run_packet(MODE_NORMAL);

    // Random payloads with random idle gaps.
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(3, 0)) tick();
      ra = 8'($urandom); rd = 8'($urandom); rb = 16'($urandom); rc = 16'($urandom);
      drive_payload(ra, rd, rb, rc);
      build_model(ra, rd, rb, rc);
      start_pkt(1'b0);
      run_packet(MODE_NORMAL);
    end
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
